// File: rtl/service_pkg.sv
// Shared types and constants for the clock-board service scheduler.
// ALARM_PREEMPT_EN adds the ALARM state to the encoding.
package service_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
`ifdef ALARM_PREEMPT_EN
    ,
    ST_ALARM  = 3'd5
`endif
  } state_e;

  localparam logic [3:0] SERVICE1     = 4'b1000;
  localparam logic [3:0] SERVICE2     = 4'b0100;
  localparam logic [3:0] SERVICE3     = 4'b0010;
  localparam logic [3:0] SERVICE4     = 4'b0001;
  localparam logic [3:0] SERVICERESET = 4'b0000;

  localparam logic [1:0] DISP_SVC1 = 2'd3;
  localparam logic [1:0] DISP_SVC2 = 2'd2;
  localparam logic [1:0] DISP_SVC3 = 2'd1;
  localparam logic [1:0] DISP_SVC4 = 2'd0;

  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != '0) && ((v & (v - 4'd1)) == '0);
  endfunction

  function automatic logic [1:0] grant_index(input logic [3:0] g);
    logic [1:0] idx;
    idx = DISP_SVC4;
    case (g)
      SERVICE1: idx = DISP_SVC1;
      SERVICE2: idx = DISP_SVC2;
      SERVICE3: idx = DISP_SVC3;
      default:  idx = DISP_SVC4;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/service_scheduler_switch_settle.sv
// Mode-switch settling: candidate pattern register plus stability counter.
// No configuration macros affect this file.
module switch_settle
  import service_pkg::*;
#(
  parameter logic [15:0] SETTLE_CYCLES = 16'd50000
) (
  input  logic       clk_osc,
  input  logic       resetn,
  input  logic [3:0] sw_i,
  input  logic       load_i,
  input  logic       track_i,
  output logic [3:0] cand_o,
  output logic       changed_o,
  output logic       stable_o
);

  logic [3:0]  cand_q, cand_d;
  logic [15:0] cnt_q, cnt_d;

  assign cand_o    = cand_q;
  assign changed_o = (sw_i != cand_q);
  assign stable_o  = (cnt_q == SETTLE_CYCLES - 16'd1);

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      cand_d = sw_i;
      cnt_d  = '0;
    end else if (track_i && (sw_i != '0)) begin
      if (changed_o) begin
        cand_d = sw_i;
        cnt_d  = '0;
      end else if (!stable_o) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_osc or negedge resetn) begin
    if (!resetn) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/service_scheduler.sv
// Grants one clock-board service at a time and gates buttons/display/LEDs to it.
// Define ALARM_PREEMPT_EN to let a rising alarm_req preempt into service 4.
module service_scheduler
  import service_pkg::*;
#(
  parameter logic [15:0] SETTLE_CYCLES = 16'd50000
) (
  input  logic        clk_osc,
  input  logic        resetn,
  input  logic [3:0]  spdt_service,
  input  logic [4:0]  push,
  input  logic [3:0]  finish,
  input  logic        alarm_req,
  output logic [3:0]  grant,
  output logic [19:0] push_out,
  output logic [1:0]  disp_sel,
  output logic        disp_blank,
  output logic [3:0]  spdt_led,
  output logic        fault
);

  state_e     state_q;
  logic [3:0] grant_q;
  logic       fault_q;
  logic [3:0] cand;
  logic       sw_changed;
  logic       sw_stable;

  switch_settle #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk_osc  (clk_osc),
    .resetn   (resetn),
    .sw_i     (spdt_service),
    .load_i   (state_q == ST_IDLE),
    .track_i  (state_q == ST_SETTLE),
    .cand_o   (cand),
    .changed_o(sw_changed),
    .stable_o (sw_stable)
  );

`ifdef ALARM_PREEMPT_EN
  logic alarm_prev_q;
`else
  logic unused_alarm;
  assign unused_alarm = alarm_req;
`endif

  always_ff @(posedge clk_osc or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      grant_q <= SERVICERESET;
      fault_q <= 1'b0;
`ifdef ALARM_PREEMPT_EN
      alarm_prev_q <= 1'b0;
`endif
    end else begin
`ifdef ALARM_PREEMPT_EN
      alarm_prev_q <= alarm_req;
      // Alarm edge outranks every other event, including a same-cycle finish.
      if (alarm_req && !alarm_prev_q && (state_q != ST_ALARM)) begin
        state_q <= ST_ALARM;
        grant_q <= SERVICE4;
        fault_q <= 1'b0;
      end else
`endif
      begin
        case (state_q)
          ST_IDLE: begin
            if (spdt_service != '0) state_q <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (spdt_service == '0) begin
              state_q <= ST_IDLE;
            end else if (!sw_changed && sw_stable) begin
              if (is_one_hot(cand)) begin
                state_q <= ST_ACTIVE;
                grant_q <= cand;
              end else begin
                state_q <= ST_FAULT;
                fault_q <= 1'b1;
              end
            end
          end
          ST_ACTIVE: begin
            if ((finish & grant_q) != '0) begin
              state_q <= ST_DONE;
              grant_q <= SERVICERESET;
            end else if (spdt_service != grant_q) begin
              state_q <= ST_IDLE;
              grant_q <= SERVICERESET;
            end
          end
          ST_DONE: begin
            if (spdt_service == '0) state_q <= ST_IDLE;
          end
          ST_FAULT: begin
            if (spdt_service == '0) begin
              state_q <= ST_IDLE;
              fault_q <= 1'b0;
            end
          end
`ifdef ALARM_PREEMPT_EN
          ST_ALARM: begin
            if (finish[0]) begin
              state_q <= ST_DONE;
              grant_q <= SERVICERESET;
            end
          end
`endif
          default: begin
            state_q <= ST_IDLE;
            grant_q <= SERVICERESET;
            fault_q <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    push_out = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      push_out[5*k +: 5] = push & {5{grant_q[k]}};
    end
  end

  always_comb begin
    spdt_led = '0;
    case (state_q)
      ST_ACTIVE: spdt_led = grant_q;
`ifdef ALARM_PREEMPT_EN
      ST_ALARM:  spdt_led = grant_q;
`endif
      ST_SETTLE: spdt_led = cand;
      default:   spdt_led = '0;
    endcase
  end

  assign grant      = grant_q;
  assign fault      = fault_q;
  assign disp_sel   = grant_index(grant_q);
  assign disp_blank = (grant_q == '0);

endmodule

// File: tb/tb_service_scheduler.sv
// Self-checking bench for service_scheduler: directed table, hand sequences, random vs model.
module tb_service_scheduler;

  localparam int SC = 4;

  logic        clk_osc;
  logic        resetn;
  logic [3:0]  spdt_service;
  logic [4:0]  push;
  logic [3:0]  finish;
  logic        alarm_req;
  logic [3:0]  grant;
  logic [19:0] push_out;
  logic [1:0]  disp_sel;
  logic        disp_blank;
  logic [3:0]  spdt_led;
  logic        fault;

  service_scheduler #(
    .SETTLE_CYCLES(16'd4)
  ) dut (
    .clk_osc     (clk_osc),
    .resetn      (resetn),
    .spdt_service(spdt_service),
    .push        (push),
    .finish      (finish),
    .alarm_req   (alarm_req),
    .grant       (grant),
    .push_out    (push_out),
    .disp_sel    (disp_sel),
    .disp_blank  (disp_blank),
    .spdt_led    (spdt_led),
    .fault       (fault)
  );

  initial clk_osc = 1'b0;
  always #5 clk_osc = ~clk_osc;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Derives the gated/display outputs from the expected owner.
  task automatic check_all(input string tag, input logic [3:0] g, input logic f,
                           input logic [3:0] led);
    logic [19:0] ep;
    logic [1:0]  es;
    ep = '0;
    es = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (g[k]) begin
        ep = 20'(push) << (5 * k);
        es = 2'(k);
      end
    end
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".fault"}, 32'(fault), 32'(f));
    chk({tag, ".led"}, 32'(spdt_led), 32'(led));
    chk({tag, ".push_out"}, 32'(push_out), 32'(ep));
    chk({tag, ".disp_sel"}, 32'(disp_sel), 32'(es));
    chk({tag, ".blank"}, 32'(disp_blank), 32'(g == 4'b0000));
  endtask

  typedef struct {
    logic [3:0] sw;
    logic [4:0] pb;
    logic [3:0] fin;
    logic [3:0] g;
    logic       f;
    logic [3:0] led;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] sw, input logic [4:0] pb, input logic [3:0] fin,
                     input logic [3:0] g, input logic f, input logic [3:0] led);
    vec_t v;
    v.sw = sw; v.pb = pb; v.fin = fin; v.g = g; v.f = f; v.led = led;
    tbl.push_back(v);
  endtask

  task automatic step(input logic [3:0] sw, input logic [4:0] pb, input logic [3:0] fin,
                      input logic al);
    spdt_service = sw;
    push         = pb;
    finish       = fin;
    alarm_req    = al;
    @(posedge clk_osc);
    #1;
  endtask

  // Reference model: phases named by meaning, settle tracked as edges seen with one pattern.
  string      ph;
  logic [3:0] pat, own;
  int         seen;
  logic       mflt;
  logic       prev_al;

  task automatic model_reset();
    ph = "idle"; pat = '0; own = '0; seen = 0; mflt = 1'b0; prev_al = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] sw, input logic [3:0] fin, input logic al);
`ifdef ALARM_PREEMPT_EN
    logic rise;
    rise = al && !prev_al;
    prev_al = al;
    if (rise && ph != "alarm") begin
      ph = "alarm"; own = 4'b0001; mflt = 1'b0;
      return;
    end
`else
    prev_al = al;
`endif
    if (ph == "idle") begin
      if (sw != 0) begin ph = "settle"; pat = sw; seen = 1; end
    end else if (ph == "settle") begin
      if (sw == 0) ph = "idle";
      else if (sw != pat) begin pat = sw; seen = 1; end
      else if (seen == SC) begin
        if ($countones(pat) == 1) begin ph = "active"; own = pat; end
        else begin ph = "fault"; mflt = 1'b1; end
      end else seen++;
    end else if (ph == "active") begin
      if ((fin & own) != 0) begin ph = "done"; own = 0; end
      else if (sw != own) begin ph = "idle"; own = 0; end
    end else if (ph == "done") begin
      if (sw == 0) ph = "idle";
    end else if (ph == "fault") begin
      if (sw == 0) begin ph = "idle"; mflt = 1'b0; end
    end else if (ph == "alarm") begin
      if (fin[0]) begin ph = "done"; own = 0; end
    end
  endtask

  function automatic logic [3:0] model_led();
    if (ph == "active" || ph == "alarm") return own;
    if (ph == "settle") return pat;
    return 4'b0000;
  endfunction

  initial begin
    logic [3:0] sw_r, fin_r;
    logic [4:0] pb_r;
    logic       al_r;
    logic [4:0] P, Q;
    P = 5'b00001;
    Q = 5'b10110;

    resetn = 1'b0; spdt_service = '0; push = 5'b11111; finish = '0; alarm_req = 1'b0;
    #12;
    chk("rst.grant", 32'(grant), 32'h0);
    chk("rst.push_out", 32'(push_out), 32'h0);
    chk("rst.disp_sel", 32'(disp_sel), 32'h0);
    chk("rst.blank", 32'(disp_blank), 32'h1);
    chk("rst.led", 32'(spdt_led), 32'h0);
    chk("rst.fault", 32'(fault), 32'h0);
    push = '0;
    @(negedge clk_osc);
    resetn = 1'b1;

    // grant after 5 edges; abort on withdraw
    for (int i = 0; i < 4; i++) add(4'b1000, P, 0, 4'b0000, 0, 4'b1000);
    add(4'b1000, P, 0, 4'b1000, 0, 4'b1000);
    add(4'b0000, P, 0, 4'b0000, 0, 4'b0000);
    // toggle restarts settling; 1000 never granted
    add(4'b1000, P, 0, 4'b0000, 0, 4'b1000);
    add(4'b1000, P, 0, 4'b0000, 0, 4'b1000);
    for (int i = 0; i < 4; i++) add(4'b0100, P, 0, 4'b0000, 0, 4'b0100);
    add(4'b0100, P, 0, 4'b0100, 0, 4'b0100);
    // finish -> DONE, no re-grant while switch held
    add(4'b0100, P, 4'b0100, 4'b0000, 0, 4'b0000);
    for (int i = 0; i < 4; i++) add(4'b0100, P, 0, 4'b0000, 0, 4'b0000);
    add(4'b0000, P, 0, 4'b0000, 0, 4'b0000);
    // multi-hot -> FAULT, cleared by withdrawing switches
    for (int i = 0; i < 4; i++) add(4'b1100, P, 0, 4'b0000, 0, 4'b1100);
    add(4'b1100, P, 0, 4'b0000, 1, 4'b0000);
    add(4'b1100, P, 0, 4'b0000, 1, 4'b0000);
    add(4'b0000, P, 0, 4'b0000, 0, 4'b0000);
    // foreign finish ignored
    for (int i = 0; i < 4; i++) add(4'b0010, Q, 0, 4'b0000, 0, 4'b0010);
    add(4'b0010, Q, 0, 4'b0010, 0, 4'b0010);
    add(4'b0010, Q, 4'b0001, 4'b0010, 0, 4'b0010);
    add(4'b0000, Q, 0, 4'b0000, 0, 4'b0000);
    // finish + switch change together: finish wins (DONE blocks resettle)
    for (int i = 0; i < 4; i++) add(4'b0100, P, 0, 4'b0000, 0, 4'b0100);
    add(4'b0100, P, 0, 4'b0100, 0, 4'b0100);
    add(4'b0000, P, 4'b0100, 4'b0000, 0, 4'b0000);
    add(4'b0100, P, 0, 4'b0000, 0, 4'b0000);
    add(4'b0000, P, 0, 4'b0000, 0, 4'b0000);
    add(4'b0100, P, 0, 4'b0000, 0, 4'b0100);

    foreach (tbl[i]) begin
      step(tbl[i].sw, tbl[i].pb, tbl[i].fin, 1'b0);
      check_all($sformatf("tbl%0d", i), tbl[i].g, tbl[i].f, tbl[i].led);
    end

    // Asynchronous reset mid-grant
    resetn = 1'b0; #1; resetn = 1'b1;
    for (int i = 0; i < 5; i++) step(4'b0001, P, 0, 1'b0);
    check_all("pre_rst", 4'b0001, 0, 4'b0001);
    #2;
    resetn = 1'b0;
    #1;
    check_all("async_rst", 4'b0000, 0, 4'b0000);
    @(posedge clk_osc); #1;
    resetn = 1'b1;
    step(4'b0000, P, 0, 1'b0);

`ifdef ALARM_PREEMPT_EN
    for (int i = 0; i < 5; i++) step(4'b1000, P, 0, 1'b0);
    check_all("al.pre", 4'b1000, 0, 4'b1000);
    step(4'b1000, P, 0, 1'b1);
    check_all("al.rise", 4'b0001, 0, 4'b0001);
    step(4'b0000, P, 4'b1000, 1'b1);
    check_all("al.hold", 4'b0001, 0, 4'b0001);
    step(4'b0000, P, 4'b0001, 1'b1);
    check_all("al.fin", 4'b0000, 0, 4'b0000);
    step(4'b0000, P, 0, 1'b0);
    step(4'b0000, P, 0, 1'b1);
    check_all("al.rise2", 4'b0001, 0, 4'b0001);
    #2;
    resetn = 1'b0;
    #1;
    check_all("al.rst", 4'b0000, 0, 4'b0000);
    @(posedge clk_osc); #1;
    resetn = 1'b1;
`endif

    // Randomized run against the model
    spdt_service = '0; finish = '0; alarm_req = 1'b0; push = '0;
    resetn = 1'b0; #1; resetn = 1'b1;
    model_reset();
    sw_r = '0;
    al_r = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 5))
          0: sw_r = 4'b0000;
          1: sw_r = 4'b1000;
          2: sw_r = 4'b0100;
          3: sw_r = 4'b0010;
          4: sw_r = 4'b0001;
          default: sw_r = 4'($urandom_range(0, 15));
        endcase
      end
      fin_r = ($urandom_range(0, 5) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      if ($urandom_range(0, 15) == 0) fin_r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) al_r = ~al_r;
      pb_r = 5'($urandom_range(0, 31));
      step(sw_r, pb_r, fin_r, al_r);
      model_step(sw_r, fin_r, al_r);
      check_all($sformatf("rnd%0d", n), own, mflt, model_led());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
